// File: rtl/decode_mac_pkg.sv
// ============================================================================
// decode_mac_pkg : shared types, parameter limits and saturation helper
// Revision 1.0   : initial release
// ============================================================================
`default_nettype none

package decode_mac_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mac_state_e;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;
  localparam int SAT_MAX_W     = 128;

  typedef logic signed [SAT_MAX_W-1:0] sat_word_t;

  // Returns 2'b01 above the signed out_w range, 2'b10 below it, 2'b00 inside.
  function automatic logic [1:0] sat_dir(input sat_word_t v, input int unsigned out_w);
    sat_word_t hi;
    sat_word_t lo;
    hi = (sat_word_t'(1) <<< (out_w - 1)) - sat_word_t'(1);
    lo = -hi - sat_word_t'(1);
    if (v > hi) return 2'b01;
    if (v < lo) return 2'b10;
    return 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_mac_pipe_if.sv
// ============================================================================
// decode_mac_pipe_if : sample/result bus of the decode MAC pipe
// Revision 1.0       : initial release
// ============================================================================
`default_nettype none

interface decode_mac_pipe_if #(
  parameter int DIN0_WIDTH = 40,
  parameter int DIN1_WIDTH = 23,
  parameter int DOUT_WIDTH = 62
);
  logic                         in_valid;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         acc_en;
  logic                         acc_last;
  logic                         out_valid;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         overflow;

  modport master (
    output in_valid, din0, din1, acc_en, acc_last,
    input  out_valid, dout, overflow
  );

  modport slave (
    input  in_valid, din0, din1, acc_en, acc_last,
    output out_valid, dout, overflow
  );
endinterface

`default_nettype wire

// File: rtl/decode_mac_shift_sat.sv
// ============================================================================
// decode_mac_shift_sat : arithmetic right shift then narrow (wrap or saturate)
// Build macro          : DECODE_MAC_SAT_EN selects saturation, else wrap
// Revision 1.0         : initial release
// ============================================================================
`default_nettype none

module decode_mac_shift_sat
  import decode_mac_pkg::*;
#(
  parameter int IN_WIDTH  = 72,
  parameter int OUT_WIDTH = 62,
  parameter int SHIFT     = 0
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        clip
);

  logic signed [IN_WIDTH-1:0] shifted;
  assign shifted = din >>> SHIFT;

  generate
    if (OUT_WIDTH >= IN_WIDTH) begin : g_widen
      assign dout = OUT_WIDTH'(shifted);
      assign clip = 1'b0;
    end else begin : g_narrow
`ifdef DECODE_MAC_SAT_EN
      logic [1:0] dir;
      assign dir = sat_dir(sat_word_t'(shifted), OUT_WIDTH);
      always_comb begin
        dout = shifted[OUT_WIDTH-1:0];
        if (dir == 2'b01)      dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (dir == 2'b10) dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end
      assign clip = |dir;
`else
      assign dout = shifted[OUT_WIDTH-1:0];
      assign clip = 1'b0;
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/decode_mac_pipe.sv
// ============================================================================
// decode_mac_pipe : pipelined signed multiplier with optional run accumulation
// Build macro     : DECODE_MAC_SAT_EN enables saturating output + sticky overflow
// Revision 1.0    : initial release
// ============================================================================
`default_nettype none

module decode_mac_pipe
  import decode_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 40,
  parameter int DIN1_WIDTH = 23,
  parameter int NUM_STAGE  = 2,   // NUM_STAGE_MIN..NUM_STAGE_MAX
  parameter int ACC_WIDTH  = 72,  // at least DIN0_WIDTH+DIN1_WIDTH
  parameter int SHIFT      = 0,
  parameter int DOUT_WIDTH = 62
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  decode_mac_pipe_if.slave  bus
);

  localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LAST = NUM_STAGE - 1;

  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         p_q [NUM_STAGE];
  logic signed [PW-1:0]         p_d [NUM_STAGE];
  logic [NUM_STAGE-1:0]         v_q, v_d, en_q, en_d, last_q, last_d;

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  mac_state_e                   state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  p_ext, sum, res;
  logic                         res_valid;

  logic signed [DOUT_WIDTH-1:0] narrowed, dout_q, dout_d;
  logic                         clip;
  logic                         out_valid_q, out_valid_d;
  logic                         overflow_q, overflow_d;

  assign prod = PW'(bus.din0) * PW'(bus.din1);

  always_comb begin
    p_d       = p_q;
    v_d       = v_q;
    en_d      = en_q;
    last_d    = last_q;
    p_d[0]    = prod;
    v_d[0]    = bus.in_valid;
    en_d[0]   = bus.acc_en;
    last_d[0] = bus.acc_last;
    for (int i = 1; i < NUM_STAGE; i++) begin
      p_d[i]    = p_q[i-1];
      v_d[i]    = v_q[i-1];
      en_d[i]   = en_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  assign p_ext = ACC_WIDTH'(p_q[LAST]);

  // Pass-through samples bypass the accumulator so they may interleave with an open run.
  always_comb begin
    acc_d     = acc_q;
    state_d   = state_q;
    res       = p_ext;
    res_valid = 1'b0;
    sum       = (state_q == RUN) ? acc_q + p_ext : p_ext;
    if (v_q[LAST]) begin
      if (!en_q[LAST]) begin
        res_valid = 1'b1;
      end else begin
        acc_d = sum;
        res   = sum;
        if (last_q[LAST]) begin
          res_valid = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d   = RUN;
        end
      end
    end
  end

  decode_mac_shift_sat #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (DOUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_shift_sat (
    .din  (res),
    .dout (narrowed),
    .clip (clip)
  );

  always_comb begin
    out_valid_d = res_valid;
    dout_d      = res_valid ? narrowed : dout_q;
    overflow_d  = overflow_q | (res_valid & clip);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q         <= '{default: '0};
      v_q         <= '0;
      en_q        <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
    end else if (ce) begin
      p_q         <= p_d;
      v_q         <= v_d;
      en_q        <= en_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_mac_pipe.sv
// ============================================================================
// tb_decode_mac_pipe : directed scoreboard bench over three configurations
// Revision 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_decode_mac_pipe;

  localparam int D0W = 40;
  localparam int D1W = 23;
  localparam int DW  = 62;
  localparam int DW1 = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic ce    = 1'b0;
  always #5 clk = ~clk;

  decode_mac_pipe_if #(.DIN0_WIDTH(D0W), .DIN1_WIDTH(D1W), .DOUT_WIDTH(DW))  bus0();
  decode_mac_pipe_if #(.DIN0_WIDTH(D0W), .DIN1_WIDTH(D1W), .DOUT_WIDTH(DW1)) bus1();
  decode_mac_pipe_if #(.DIN0_WIDTH(D0W), .DIN1_WIDTH(D1W), .DOUT_WIDTH(DW))  bus2();

  decode_mac_pipe #(.NUM_STAGE(2)) u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus0));
  decode_mac_pipe #(.NUM_STAGE(1), .SHIFT(4), .DOUT_WIDTH(DW1)) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus1));
  decode_mac_pipe #(.NUM_STAGE(4)) u_dut2 (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus2));

  typedef struct {
    longint val;
    bit     ovf;
    int     et;
    int     rt;
    int     rlat;
  } exp_t;

  exp_t   q[3][$];
  longint m_acc[3];
  bit     m_run[3];
  bit     m_ovf[3];
  int     n_out[3];
  int     exp_out[3];
  int     ecyc = 0;
  int     rcyc = 0;
  bit     ce_edge = 1'b0;
  int     checks = 0;
  int     passes = 0;
  int     fails  = 0;

  always @(posedge clk) begin
    rcyc    <= rcyc + 1;
    if (ce) ecyc <= ecyc + 1;
    ce_edge <= ce;
  end

  function automatic int lat(int inst);
    case (inst)
      0:       return 3;
      1:       return 2;
      default: return 5;
    endcase
  endfunction

  // Reference narrowing: instance 1 uses SHIFT=4 into 8 bits, the others fit unchanged.
  function automatic longint narrow(int inst, longint r, output bit clip);
    longint s;
    clip = 1'b0;
    if (inst != 1) return r;
    s = r >>> 4;
`ifdef DECODE_MAC_SAT_EN
    if (s > 127)  begin clip = 1'b1; return 127;  end
    if (s < -128) begin clip = 1'b1; return -128; end
    return s;
`else
    begin
      logic [7:0] b8;
      b8 = s[7:0];
      return longint'($signed(b8));
    end
`endif
  endfunction

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic on_out(int inst, longint d, bit ov);
    exp_t e;
    n_out[inst]++;
    if (q[inst].size() == 0) begin
      chk($sformatf("spurious_out%0d", inst), 1, 0);
      return;
    end
    e = q[inst].pop_front();
    chk($sformatf("dout%0d", inst), d, e.val);
    chk($sformatf("latency%0d", inst), ecyc - e.et, lat(inst));
    if (e.rlat >= 0) chk($sformatf("stall_latency%0d", inst), rcyc - e.rt, e.rlat);
    chk($sformatf("overflow%0d", inst), ov, e.ovf);
  endtask

  always @(negedge clk) begin
    if (reset && ce_edge) begin
      if (bus0.out_valid) on_out(0, longint'($signed(bus0.dout)), bus0.overflow);
      if (bus1.out_valid) on_out(1, longint'($signed(bus1.dout)), bus1.overflow);
      if (bus2.out_valid) on_out(2, longint'($signed(bus2.dout)), bus2.overflow);
    end
  end

  task automatic clear_inputs();
    bus0.in_valid = 1'b0; bus0.acc_en = 1'b0; bus0.acc_last = 1'b0;
    bus1.in_valid = 1'b0; bus1.acc_en = 1'b0; bus1.acc_last = 1'b0;
    bus2.in_valid = 1'b0; bus2.acc_en = 1'b0; bus2.acc_last = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic drive(int inst, longint a, longint b, bit en, bit last, int rlat = -1);
    longint p;
    longint r;
    bit     push;
    bit     clip;
    exp_t   e;
    @(negedge clk);
    clear_inputs();
    case (inst)
      0: begin bus0.in_valid = 1'b1; bus0.din0 = D0W'(a); bus0.din1 = D1W'(b);
               bus0.acc_en = en; bus0.acc_last = last; end
      1: begin bus1.in_valid = 1'b1; bus1.din0 = D0W'(a); bus1.din1 = D1W'(b);
               bus1.acc_en = en; bus1.acc_last = last; end
      default: begin bus2.in_valid = 1'b1; bus2.din0 = D0W'(a); bus2.din1 = D1W'(b);
               bus2.acc_en = en; bus2.acc_last = last; end
    endcase
    p    = a * b;
    r    = p;
    push = 1'b0;
    if (!en) begin
      push = 1'b1;
    end else begin
      r = m_run[inst] ? m_acc[inst] + p : p;
      m_acc[inst] = r;
      m_run[inst] = !last;
      push = last;
    end
    if (push) begin
      e.val = narrow(inst, r, clip);
      m_ovf[inst] = m_ovf[inst] | clip;
      e.ovf  = m_ovf[inst];
      e.et   = ecyc;
      e.rt   = rcyc;
      e.rlat = rlat;
      q[inst].push_back(e);
      exp_out[inst]++;
    end
  endtask

  initial begin
    clear_inputs();
    bus0.din0 = '0; bus0.din1 = '0;
    bus1.din0 = '0; bus1.din1 = '0;
    bus2.din0 = '0; bus2.din1 = '0;
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_run[i] = 1'b0; m_ovf[i] = 1'b0; n_out[i] = 0; exp_out[i] = 0;
    end
    reset = 1'b0;
    ce    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid0", bus0.out_valid, 0);
    chk("rst_dout0",      bus0.dout, 0);
    chk("rst_overflow0",  bus0.overflow, 0);
    chk("rst_out_valid1", bus1.out_valid, 0);
    chk("rst_dout1",      bus1.dout, 0);
    chk("rst_overflow1",  bus1.overflow, 0);
    chk("rst_out_valid2", bus2.out_valid, 0);
    reset = 1'b1;

    drive(0, -3, 7, 1'b0, 1'b0);
    idle(5);

    for (int k = 1; k <= 4; k++) drive(0, k, 1, 1'b1, k == 4);
    idle(6);

    drive(0, 5, 1, 1'b1, 1'b0);
    drive(0, 2, 3, 1'b0, 1'b0);
    drive(0, 7, 1, 1'b1, 1'b1);
    idle(6);

    // Stall five edges with the sample one stage in; a sample offered while stalled must be ignored.
    drive(0, -5, 9, 1'b0, 1'b0, 8);
    @(negedge clk);
    clear_inputs();
    ce = 1'b0;
    bus0.in_valid = 1'b1; bus0.din0 = D0W'(100); bus0.din1 = D1W'(1);
    repeat (5) @(negedge clk);
    clear_inputs();
    ce = 1'b1;
    idle(6);

    drive(0, 1, 1, 1'b1, 1'b0);
    drive(0, 1, 1, 1'b1, 1'b0);
    idle(3);
    drive(0, 9, 9, 1'b0, 1'b0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #1;
    chk("async_rst_dout0",      bus0.dout, 0);
    chk("async_rst_out_valid0", bus0.out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      m_run[i] = 1'b0; m_ovf[i] = 1'b0; n_out[i] = 0; exp_out[i] = 0;
    end
    @(negedge clk);
    reset = 1'b1;
    drive(0, 5, 1, 1'b1, 1'b1);
    idle(6);

    drive(1, longint'(1) <<< 20, 1, 1'b0, 1'b0);
    idle(4);
`ifdef DECODE_MAC_SAT_EN
    chk("sat_overflow_flag", bus1.overflow, 1);
`else
    chk("sat_overflow_flag", bus1.overflow, 0);
`endif
    drive(1, -(longint'(1) <<< 20), 1, 1'b0, 1'b0);
    drive(1, 5 * 16, 1, 1'b0, 1'b0);
    idle(4);

    for (int k = 0; k < 16; k++)
      drive(1, (longint'($urandom_range(0, 14)) - 7) * 16, longint'($urandom_range(0, 14)) - 7,
            1'b0, 1'b0);
    idle(4);

    for (int k = 0; k < 16; k++)
      drive(2, longint'($urandom_range(0, 2000000)) - 1000000,
            longint'($urandom_range(0, 200000)) - 100000, 1'b0, 1'b0);
    idle(8);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("queue_empty%0d", i), q[i].size(), 0);
      chk($sformatf("out_count%0d", i), n_out[i], exp_out[i]);
    end
    chk("stream_count1", exp_out[1], 19);
    chk("stream_count2", n_out[2], 16);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_mac_pipe.md
# decode_mac_pipe

Parametrised successor to the fixed two-stage signed multiplier in the decode datapath. Multiplies signed operands through a configurable pipeline, tracks sample validity alongside the data, and optionally accumulates a run of products into a wide accumulator. The result is scaled by an arithmetic right shift before output. It sits between the decode coefficient fetch and the output quantiser, and replaces per-width multiplier instances.

## Interface
- DIN0_WIDTH, 40: signed operand A width
- DIN1_WIDTH, 23: signed operand B width
- NUM_STAGE, 2: multiplier pipeline registers; legal range 1..4
- ACC_WIDTH, 72: accumulator width; must be ≥ DIN0_WIDTH+DIN1_WIDTH
- SHIFT, 0: arithmetic right shift applied before narrowing; legal range 0..ACC_WIDTH-1
- DOUT_WIDTH, 62: output width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state
- ce  in  1  global clock enable; 0 freezes every register
- in_valid  in  1  din0/din1/acc_en/acc_last carry a sample
- din0  in  DIN0_WIDTH  signed operand A
- din1  in  DIN1_WIDTH  signed operand B
- acc_en  in  1  sample belongs to an accumulation run
- acc_last  in  1  final sample of the run; ignored when acc_en=0
- out_valid  out  1  dout holds a new result this cycle
- dout  out  DOUT_WIDTH  signed result
- overflow  out  1  sticky narrowing-overflow flag

## Operation
- Product P = din0 × din1, signed, full width PW = DIN0_WIDTH+DIN1_WIDTH. No precision is lost in the pipeline.
- Pipeline: NUM_STAGE registers carry P. The valid, acc_en and acc_last bits travel alongside P in lockstep.
- Final stage (accumulator stage) is always present. Two-state control:
  - IDLE: no run is open.
  - RUN: a run is open.
- At the final stage, with ce=1 and a valid sample arriving:
  - acc_en=0 (pass-through): R = sext(P) to ACC_WIDTH. out_valid=1. State is unchanged.
  - acc_en=1 in IDLE: acc = sext(P). Go to RUN.
  - acc_en=1 in RUN: acc = acc + sext(P), wrapping at ACC_WIDTH.
  - acc_en=1 with acc_last=1: R = the updated acc. out_valid=1. Go to IDLE. A single-sample run (IDLE with last=1) emits sext(P).
- A pass-through sample arriving during RUN is emitted and leaves acc and the state untouched. Interleaving is legal.
- Output: dout = narrow(R >>> SHIFT). Narrowing is per Configuration.
- In cycles with no valid result, dout holds its last value and out_valid=0.

## Timing
- Reset values: out_valid=0, dout=0, overflow=0, acc=0, state IDLE, all pipeline valid bits 0. Reset takes effect immediately, without a clock edge.
- Latency: NUM_STAGE+1 enabled cycles from an in_valid sample to its out_valid. Throughput is one sample per enabled cycle.
- ce=0 stalls the whole pipe: out_valid holds its value, and in_valid is not sampled. Latency counts only ce=1 cycles.
- Reset asserted mid-run discards the partial accumulation and all in-flight samples. Nothing is emitted.
- No backpressure: the consumer must accept every out_valid cycle.

## Configuration
- DECODE_MAC_SAT_EN defined:
  - Narrowing saturates to [−2^(DOUT_WIDTH−1), 2^(DOUT_WIDTH−1)−1].
  - overflow sets on any clipped output and stays set until reset.
- DECODE_MAC_SAT_EN undefined:
  - Narrowing keeps the low DOUT_WIDTH bits (wraps).
  - overflow is tied to 0.

## Structure
- Shared package decode_mac_pkg holds:
  - the state enum (IDLE, RUN)
  - the parameter legality limits (NUM_STAGE_MIN=1, NUM_STAGE_MAX=4)
  - the saturate-function helper
- One sub-module, decode_mac_shift_sat, performs the combinational shift and narrow/saturate. It is reused by the quantiser.

## Test plan
- Pass-through, defaults: din0=−3, din1=7, acc_en=0 → out_valid exactly 3 cycles later, dout=−21.
- Run of 4 samples: products 1, 2, 3, 4 with acc_last on the 4th → a single out_valid, dout=10. No output for the first three.
- Stall: drop ce for 5 cycles mid-flight → result appears 5 cycles later with the value unchanged, and out_valid is never duplicated.
- Reset mid-run: 2 samples accumulated, reset pulsed low, then a 1-sample run of 5 → dout=5.
- SHIFT=4, DOUT_WIDTH=8, din0=2^20, din1=1:
  - DECODE_MAC_SAT_EN defined → dout=127, overflow=1.
  - DECODE_MAC_SAT_EN undefined → dout=0, overflow=0.
- NUM_STAGE=1 and NUM_STAGE=4 each: a back-to-back stream of 16 samples yields 16 results at latency 2 and 5 respectively.
